timing_sweep_ctrl: RTL and testbench

- Sequences the send_guess transaction engine through a full timing-attack sweep.
- For each code byte position, every candidate byte is sent REPEATS times. Reply latencies are summed, and the candidate with the largest summed latency is committed.
- Replaces the single-shot guess FSM. Repetition averages out MCU jitter. Adds an ack timeout, status outputs and a re-armable start.

---
 rtl/sweep_pkg.sv | 22 ++
 rtl/timing_sweep_ctrl_if.sv | 24 ++
 rtl/timing_sweep_ctrl_latency_meter.sv | 42 ++++
 rtl/timing_sweep_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_timing_sweep_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sweep_pkg.sv
// Shared constants for the timing-attack sweep controller.
// State encodings and MCU protocol bytes.
package sweep_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ISSUE   = 3'd1;
    localparam state_t S_MEASURE = 3'd2;
    localparam state_t S_ACCUM   = 3'd3;
    localparam state_t S_COMPARE = 3'd4;
    localparam state_t S_COMMIT  = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    localparam logic [7:0] START_BYTE        = 8'h01;
    localparam logic [7:0] BEGIN_GUESSING    = 8'h02;
    localparam logic [7:0] GUESS_BYTE        = 8'h03;
    localparam logic [7:0] CORRECT_BYTE      = 8'h04;
    localparam logic [7:0] WRONG_BYTE        = 8'h05;
    localparam logic [7:0] START_GUESS_RANGE = 8'h06;

endpackage

// File: rtl/timing_sweep_ctrl_if.sv
// Handshake bundle between the sweep controller
// and the send_guess transaction engine.
interface timing_sweep_ctrl_if #(
    parameter int CODE_LEN = 2
);
    logic [7:0]            data_from_mcu;
    logic                  waiting_for_reply;
    logic                  begin_transaction;
    logic [8*CODE_LEN-1:0] guess_flat;

    modport master (
        input  data_from_mcu,
        input  waiting_for_reply,
        output begin_transaction,
        output guess_flat
    );

    modport slave (
        output data_from_mcu,
        output waiting_for_reply,
        input  begin_transaction,
        input  guess_flat
    );
endinterface

// File: rtl/timing_sweep_ctrl_latency_meter.sv
// Saturating reply-latency counter plus the
// ack-timeout counter used while a request is pending.
module latency_meter #(
    parameter int CNT_W = 24,
    parameter int ACK_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ack_en,
    output logic [CNT_W-1:0] lat,
    output logic [ACK_W-1:0] ack_cnt
);

    logic [CNT_W-1:0] lat_q, lat_d;
    logic [ACK_W-1:0] ack_q, ack_d;

    always_comb begin
        lat_d = lat_q;
        if (clr) begin
            lat_d = '0;
        end else if (en && (lat_q != {CNT_W{1'b1}})) begin
            lat_d = lat_q + 1'b1;
        end
        ack_d = ack_en ? ack_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= '0;
            ack_q <= '0;
        end else begin
            lat_q <= lat_d;
            ack_q <= ack_d;
        end
    end

    assign lat     = lat_q;
    assign ack_cnt = ack_q;

endmodule

// File: rtl/timing_sweep_ctrl.sv
// Timing-attack sweep: every candidate is sent REPEATS times,
// latencies are summed and the slowest candidate is committed.
module timing_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int         CODE_LEN    = 2,
    parameter int         REPEATS     = 4,
    parameter logic [7:0] START_GUESS = START_GUESS_RANGE,
    parameter logic [7:0] END_GUESS   = 8'hFF,
    parameter int         CNT_W       = 24,
    parameter int         ACK_TIMEOUT = 1000
) (
    input  logic                  CLK_50,
    input  logic [0:0]            SW,
    timing_sweep_ctrl_if.master   eng,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [8*CODE_LEN-1:0] code_flat,
    output logic [7:0]            LED
);

    localparam int SUM_W = CNT_W + $clog2(REPEATS);
    localparam int REP_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int POS_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef logic [CODE_LEN-1:0][7:0] word_t;

    state_t           state_q, state_d;
    logic [7:0]       cand_q, cand_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] best_sum_q, best_sum_d;
    logic [7:0]       best_byte_q, best_byte_d;
    word_t            code_q, code_d;
    word_t            guess_q, guess_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;
    logic             armed_q, armed_d;

    logic             in_issue;
    logic             in_measure;
    logic [CNT_W-1:0] lat;
    logic [ACK_W-1:0] ack_cnt;

    function automatic word_t build_guess(
        input logic [POS_W-1:0] p,
        input logic [7:0]       c,
        input word_t            code
    );
        word_t g;
        for (int k = 0; k < CODE_LEN; k++) begin
            g[k] = (p == POS_W'(k)) ? c : code[k];
        end
        return g;
    endfunction

    assign in_issue   = (state_q == S_ISSUE);
    assign in_measure = (state_q == S_MEASURE);

    latency_meter #(
        .CNT_W (CNT_W),
        .ACK_W (ACK_W)
    ) u_meter (
        .clk     (CLK_50),
        .rst     (SW[0]),
        .clr     (in_issue),
        .en      (in_measure),
        .ack_en  (in_issue),
        .lat     (lat),
        .ack_cnt (ack_cnt)
    );

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        pos_d       = pos_q;
        rep_d       = rep_q;
        sum_d       = sum_q;
        best_sum_d  = best_sum_q;
        best_byte_d = best_byte_q;
        code_d      = code_q;
        done_d      = done_q;
        terr_d      = terr_q;
        armed_d     = armed_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A held start byte must drop once before DONE re-arms
                if (state_q == S_DONE &&
                    eng.data_from_mcu != BEGIN_GUESSING) begin
                    armed_d = 1'b1;
                end
                if (eng.data_from_mcu == BEGIN_GUESSING &&
                    (state_q == S_IDLE || armed_q)) begin
                    state_d     = S_ISSUE;
                    done_d      = 1'b0;
                    terr_d      = 1'b0;
                    armed_d     = 1'b0;
                    pos_d       = '0;
                    rep_d       = '0;
                    sum_d       = '0;
                    best_sum_d  = '0;
                    best_byte_d = START_GUESS;
                    cand_d      = START_GUESS;
                end
            end
            S_ISSUE: begin
                if (eng.waiting_for_reply) begin
                    state_d = S_MEASURE;
                end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_MEASURE: begin
                if (!eng.waiting_for_reply) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // lat is still zero after a timeout, so it adds nothing
                sum_d = sum_q + SUM_W'(lat);
                rep_d = rep_q + 1'b1;
                if (rep_q == REP_W'(REPEATS - 1)) begin
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_COMPARE: begin
                if (sum_q > best_sum_q) begin
                    best_sum_d  = sum_q;
                    best_byte_d = cand_q;
                end
                sum_d = '0;
                rep_d = '0;
                if (cand_q == END_GUESS) begin
                    state_d = S_COMMIT;
                end else begin
                    cand_d  = cand_q + 8'd1;
                    state_d = S_ISSUE;
                end
            end
            S_COMMIT: begin
                code_d[pos_q] = best_byte_q;
                cand_d        = START_GUESS;
                best_sum_d    = '0;
                best_byte_d   = START_GUESS;
                if (pos_q == POS_W'(CODE_LEN - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pos_d   = pos_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        guess_d = build_guess(pos_d, cand_d, code_d);
    end

    always_ff @(posedge CLK_50) begin
        if (SW[0]) begin
            state_q     <= S_IDLE;
            cand_q      <= START_GUESS;
            pos_q       <= '0;
            rep_q       <= '0;
            sum_q       <= '0;
            best_sum_q  <= '0;
            best_byte_q <= START_GUESS;
            code_q      <= '0;
            guess_q     <= build_guess('0, START_GUESS, '0);
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            pos_q       <= pos_d;
            rep_q       <= rep_d;
            sum_q       <= sum_d;
            best_sum_q  <= best_sum_d;
            best_byte_q <= best_byte_d;
            code_q      <= code_d;
            guess_q     <= guess_d;
            done_q      <= done_d;
            terr_q      <= terr_d;
            armed_q     <= armed_d;
        end
    end

    assign eng.begin_transaction = in_issue;
    assign eng.guess_flat        = guess_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign code_flat   = code_q;
    assign LED         = cand_q;

endmodule

// File: tb/tb_timing_sweep_ctrl.sv
// Bench for timing_sweep_ctrl: a delay-table MCU/engine
// model drives two parameterisations, checked against a sum/argmax model.
module tb_timing_sweep_ctrl;

    localparam int REP = 4;
    localparam int AT  = 30;

    logic       clk = 1'b0;
    logic [0:0] sw  = 1'b1;

    timing_sweep_ctrl_if #(.CODE_LEN(2)) if0 ();
    timing_sweep_ctrl_if #(.CODE_LEN(2)) if1 ();

    logic        busy0, done0, terr0;
    logic        busy1, done1, terr1;
    logic [15:0] code0, code1;
    logic [7:0]  led0, led1;

    timing_sweep_ctrl #(
        .CODE_LEN(2), .REPEATS(REP),
        .START_GUESS(8'hFE), .END_GUESS(8'hFF),
        .CNT_W(24), .ACK_TIMEOUT(AT)
    ) u0 (
        .CLK_50(clk), .SW(sw), .eng(if0),
        .busy(busy0), .done(done0), .timeout_err(terr0),
        .code_flat(code0), .LED(led0)
    );

    timing_sweep_ctrl #(
        .CODE_LEN(2), .REPEATS(REP),
        .START_GUESS(8'h28), .END_GUESS(8'h2C),
        .CNT_W(24), .ACK_TIMEOUT(AT)
    ) u1 (
        .CLK_50(clk), .SW(sw), .eng(if1),
        .busy(busy1), .done(done1), .timeout_err(terr1),
        .code_flat(code1), .LED(led1)
    );

    initial forever #5 clk = ~clk;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic sel = 1'b0;
    int   txn = 0;
    int   rises = 0;
    int   drop_idx = -1;
    int   hi_cnt = 0;
    int   cnt = 0;
    logic w = 1'b0;
    logic bt_prev = 1'b0;

    int         dly [2][5][REP];
    logic [7:0] exp_new [2];
    logic [7:0] prev_code [2][2];

    logic        busy_s, done_s, terr_s, bt_s;
    logic [15:0] code_s, guess_s;
    logic [7:0]  led_s;

    assign busy_s  = sel ? busy1 : busy0;
    assign done_s  = sel ? done1 : done0;
    assign terr_s  = sel ? terr1 : terr0;
    assign code_s  = sel ? code1 : code0;
    assign led_s   = sel ? led1 : led0;
    assign bt_s    = sel ? if1.begin_transaction : if0.begin_transaction;
    assign guess_s = sel ? if1.guess_flat : if0.guess_flat;

    function automatic int nc(input logic s);
        return s ? 5 : 2;
    endfunction

    function automatic logic [7:0] st(input logic s);
        return s ? 8'h28 : 8'hFE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine/MCU model: raises waiting_for_reply on each new request and
    // holds it for the tabled number of cycles; one request may be dropped.
    initial begin
        logic       b;
        int         p, ci, r;
        logic [7:0] eb [2];
        if0.waiting_for_reply = 1'b0;
        if1.waiting_for_reply = 1'b0;
        forever begin
            @(negedge clk);
            b = bt_s;
            if (b && !bt_prev) begin
                rises++;
                p  = txn / (nc(sel) * REP);
                ci = (txn / REP) % nc(sel);
                r  = txn % REP;
                if (p > 1) p = 1;
                for (int k = 0; k < 2; k++) begin
                    if (k < p) eb[k] = exp_new[k];
                    else if (k == p) eb[k] = 8'(int'(st(sel)) + ci);
                    else eb[k] = prev_code[sel][k];
                end
                chk("guess_flat", {16'h0, guess_s}, {16'h0, eb[1], eb[0]});
                if (txn != drop_idx) begin
                    w   = 1'b1;
                    cnt = dly[p][ci][r];
                end
                txn++;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) w = 1'b0;
            end
            if (b && drop_idx >= 0 && txn - 1 == drop_idx) hi_cnt++;
            bt_prev = b;
            if0.waiting_for_reply = !sel && w;
            if1.waiting_for_reply = sel && w;
        end
    end

    task automatic fill(input int lo, input int hi);
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 5; c++)
                for (int r = 0; r < REP; r++)
                    dly[p][c][r] = (lo == hi) ? lo : int'($urandom_range(hi, lo));
    endtask

    task automatic set_cand(input int p, input int c, input int d);
        for (int r = 0; r < REP; r++) dly[p][c][r] = d;
    endtask

    task automatic drive_data(input logic [7:0] v);
        if (sel) if1.data_from_mcu = v;
        else if0.data_from_mcu = v;
    endtask

    task automatic start_sweep(input logic s);
        int sum, bsum, idx;
        logic [7:0] bb;
        sel = s;
        for (int p = 0; p < 2; p++) begin
            bsum = 0;
            bb   = st(s);
            for (int c = 0; c < nc(s); c++) begin
                sum = 0;
                for (int r = 0; r < REP; r++) begin
                    idx = (p * nc(s) + c) * REP + r;
                    if (idx != drop_idx) sum += dly[p][c][r];
                end
                if (sum > bsum) begin
                    bsum = sum;
                    bb   = 8'(int'(st(s)) + c);
                end
            end
            exp_new[p] = bb;
        end
        txn = 0; rises = 0; hi_cnt = 0;
        w = 1'b0; cnt = 0; bt_prev = 1'b0;
        drive_data(8'h00);
        @(posedge clk); #1;
        drive_data(8'h02);
        @(posedge clk); #1;
        chk("start_busy", {31'h0, busy_s}, 32'h1);
    endtask

    task automatic wait_done(input logic exp_terr);
        int c;
        c = 0;
        while (!done_s && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done", {31'h0, done_s}, 32'h1);
        chk("code_flat", {16'h0, code_s}, {16'h0, exp_new[1], exp_new[0]});
        chk("busy_end", {31'h0, busy_s}, 32'h0);
        chk("timeout_err", {31'h0, terr_s}, {31'h0, exp_terr});
        chk("led_end", {24'h0, led_s}, {24'h0, st(sel)});
        chk("rises", rises, 2 * nc(sel) * REP);
        prev_code[sel][0] = exp_new[0];
        prev_code[sel][1] = exp_new[1];
    endtask

    task automatic chk_reset();
        chk("rst_busy0", {31'h0, busy0}, 32'h0);
        chk("rst_busy1", {31'h0, busy1}, 32'h0);
        chk("rst_done", {30'h0, done1, done0}, 32'h0);
        chk("rst_terr", {30'h0, terr1, terr0}, 32'h0);
        chk("rst_bt", {30'h0, if1.begin_transaction,
                       if0.begin_transaction}, 32'h0);
        chk("rst_code", {code1, code0}, 32'h0);
        chk("rst_led", {16'h0, led1, led0}, 32'h28FE);
        chk("rst_guess", {if1.guess_flat, if0.guess_flat}, 32'h002800FE);
    endtask

    initial begin
        int c;
        if0.data_from_mcu = 8'h00;
        if1.data_from_mcu = 8'h00;
        for (int s = 0; s < 2; s++) begin
            prev_code[s][0] = 8'h00;
            prev_code[s][1] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        sw = 1'b0;
        @(posedge clk); #1;

        // Equal latencies everywhere: tie rule keeps the first candidate
        fill(10, 10);
        start_sweep(1'b0);
        wait_done(1'b0);

        fill(10, 10);
        set_cand(0, 2, 40);
        set_cand(1, 3, 40);
        start_sweep(1'b1);
        wait_done(1'b0);
        chk("code_2b2a", {16'h0, code1}, 32'h2B2A);

        // Start byte still held: DONE must not restart
        repeat (10) @(posedge clk);
        #1;
        chk("hold_busy", {31'h0, busy1}, 32'h0);
        chk("hold_done", {31'h0, done1}, 32'h1);
        chk("hold_rises", rises, 2 * 5 * REP);

        fill(10, 10);
        dly[0][1][0] = 100;
        set_cand(0, 2, 40);
        set_cand(1, 4, 40);
        start_sweep(1'b1);
        wait_done(1'b0);
        chk("jitter", {16'h0, code1}, 32'h2C2A);

        fill(5, 15);
        set_cand(0, 4, 60);
        set_cand(1, 0, 60);
        drop_idx = 6;
        start_sweep(1'b1);
        wait_done(1'b1);
        chk("ack_hold", hi_cnt, AT);
        drop_idx = -1;

        for (int i = 0; i < 3; i++) begin
            fill(2, 40);
            start_sweep(1'b1);
            wait_done(1'b0);
        end

        // Reset while byte 1 is being measured
        if0.data_from_mcu = 8'h00;
        fill(5, 30);
        start_sweep(1'b1);
        c = 0;
        while (!(txn > 5 * REP && if1.waiting_for_reply &&
                 !if1.begin_transaction) && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst_reach", {31'h0, c < 5000}, 32'h1);
        sw = 1'b1;
        @(posedge clk); #1;
        chk("mid_busy", {31'h0, busy1}, 32'h0);
        chk("mid_bt", {31'h0, if1.begin_transaction}, 32'h0);
        chk("mid_code", {16'h0, code1}, 32'h0);
        chk("mid_done", {31'h0, done1}, 32'h0);
        chk("mid_led", {24'h0, led1}, 32'h28);
        for (int s = 0; s < 2; s++) begin
            prev_code[s][0] = 8'h00;
            prev_code[s][1] = 8'h00;
        end
        sw = 1'b0;
        @(posedge clk); #1;
        fill(2, 40);
        start_sweep(1'b1);
        wait_done(1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
